// File: rtl/frequency_divider_prog.sv
// Runtime-programmable integer clock divider: square-wave clk_out, one-cycle tick per period,
// with ratio updates deferred to the next period boundary so no runt pulses are produced.
module frequency_divider_prog #(
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 10
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div_value,
  input  logic                 div_load,
  output logic                 clk_out,
  output logic                 tick,
  output logic                 load_pending
);

  localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] active_div;
  logic [DIV_WIDTH-1:0] pend_div;
  logic                 pend_flag;
  logic [DIV_WIDTH-1:0] cnt;

  logic [DIV_WIDTH-1:0] load_val;
  logic [DIV_WIDTH-1:0] next_div;
  logic [DIV_WIDTH-1:0] next_cnt;
  logic [DIV_WIDTH:0]   half_next;
  logic                 wrap;

  // The high-phase length uses the ratio in force after this edge, so a new ratio shapes its very first period.
  always_comb begin
    load_val  = (div_value < MIN_DIV) ? MIN_DIV : div_value;
    wrap      = en && (cnt == active_div - ONE);
    next_div  = active_div;
    if (wrap) begin
      if (div_load)
        next_div = load_val;
      else if (pend_flag)
        next_div = pend_div;
    end
    next_cnt  = wrap ? '0 : cnt + ONE;
    half_next = ({1'b0, next_div} + (DIV_WIDTH + 1)'(1)) >> 1;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      active_div <= DEF_DIV;
      pend_div   <= DEF_DIV;
      pend_flag  <= 1'b0;
      cnt        <= DEF_DIV - ONE;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
    end else begin
      tick <= wrap;
      if (wrap) begin
        active_div <= next_div;
        pend_flag  <= 1'b0;
      end else if (div_load) begin
        pend_div  <= load_val;
        pend_flag <= 1'b1;
      end
      if (en) begin
        cnt     <= next_cnt;
        clk_out <= ({1'b0, next_cnt} < half_next);
      end
    end
  end

  assign load_pending = pend_flag;

endmodule

// File: tb/tb_frequency_divider_prog.sv
// Self-checking bench for frequency_divider_prog: a cycle model feeds a scoreboard queue,
// and each scenario task also checks period/duty/tick positions against hand-derived values.
module tb_frequency_divider_prog;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] div_value = '0;
  logic        div_load = 1'b0;
  logic        clk_out;
  logic        tick;
  logic        load_pending;

  int vectors = 0;
  int miscompares = 0;

  logic [2:0] sb[$];
  logic [2:0] exp_v;

  int m_active, m_pend, m_cnt;
  bit m_pflag, m_out, m_tick;

  frequency_divider_prog #(.DIV_WIDTH(16), .DEFAULT_DIV(10)) dut (
    .clk_in(clk_in),
    .rst(rst),
    .en(en),
    .div_value(div_value),
    .div_load(div_load),
    .clk_out(clk_out),
    .tick(tick),
    .load_pending(load_pending)
  );

  always #10 clk_in = ~clk_in;

  function automatic int clamp(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  // Applies one cycle of stimulus, advances the reference model, and queues the expected outputs.
  task automatic drive(input bit r, input bit e, input bit l, input int v);
    bit w;
    rst = r; en = e; div_load = l; div_value = 16'(v);
    @(posedge clk_in);
    if (r) begin
      m_active = 10; m_cnt = 9; m_pflag = 0; m_out = 0; m_tick = 0;
    end else begin
      w = e && (m_cnt == m_active - 1);
      if (w) begin
        if (l) m_active = clamp(v);
        else if (m_pflag) m_active = m_pend;
        m_pflag = 0;
      end else if (l) begin
        m_pend = clamp(v);
        m_pflag = 1;
      end
      if (e) begin
        m_cnt = w ? 0 : m_cnt + 1;
        m_out = (m_cnt < (m_active + 1) / 2);
      end
      m_tick = w;
    end
    sb.push_back({m_out, m_tick, m_pflag});
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 3);
    drive(1, 0, 0, 0);
    exp_v = sb.pop_front(); vectors++;
    if ({clk_out, tick, load_pending} !== exp_v) begin
      miscompares++; $display("[TB] FAIL reset_sb: got %b expected %b", {clk_out, tick, load_pending}, exp_v);
    end
    exp_v = sb.pop_front(); vectors++;
    if ({clk_out, tick, load_pending} !== 3'b000) begin
      miscompares++; $display("[TB] FAIL reset_state: got %b expected 000", {clk_out, tick, load_pending});
    end
  endtask

  task automatic test_default_period();
    int ticks[$];
    int highs = 0;
    drive(1, 0, 0, 0); void'(sb.pop_front());
    for (int i = 1; i <= 30; i++) begin
      drive(0, 1, 0, 0);
      exp_v = sb.pop_front(); vectors++;
      if ({clk_out, tick, load_pending} !== exp_v) begin
        miscompares++; $display("[TB] FAIL default_sb cyc %0d: got %b expected %b", i, {clk_out, tick, load_pending}, exp_v);
      end
      if (tick) ticks.push_back(i);
      if (clk_out) highs++;
      if (i == 1 && {clk_out, tick} !== 2'b11) begin
        miscompares++; $display("[TB] FAIL default_first_rise: got %b expected 11", {clk_out, tick});
      end
    end
    vectors++;
    if (ticks.size() != 3 || ticks[0] != 1 || ticks[1] != 11 || ticks[2] != 21) begin
      miscompares++; $display("[TB] FAIL default_ticks: got %p expected '{1,11,21}", ticks);
    end
    vectors++;
    if (highs != 15) begin
      miscompares++; $display("[TB] FAIL default_duty: got %0d high expected 15", highs);
    end
  endtask

  task automatic test_load_mid();
    int ticks[$];
    int highs = 0;
    drive(1, 0, 0, 0); void'(sb.pop_front());
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, i == 4, 5);
      exp_v = sb.pop_front(); vectors++;
      if ({clk_out, tick, load_pending} !== exp_v) begin
        miscompares++; $display("[TB] FAIL loadmid_sb pre %0d: got %b expected %b", i, {clk_out, tick, load_pending}, exp_v);
      end
    end
    vectors++;
    if (load_pending !== 1'b1) begin
      miscompares++; $display("[TB] FAIL loadmid_pending: got %b expected 1", load_pending);
    end
    for (int i = 1; i <= 20; i++) begin
      drive(0, 1, 0, 0);
      exp_v = sb.pop_front(); vectors++;
      if ({clk_out, tick, load_pending} !== exp_v) begin
        miscompares++; $display("[TB] FAIL loadmid_sb cyc %0d: got %b expected %b", i, {clk_out, tick, load_pending}, exp_v);
      end
      if (tick) ticks.push_back(i);
      if (i >= 7 && i <= 11 && clk_out) highs++;
      if (i == 7 && load_pending !== 1'b0) begin
        miscompares++; $display("[TB] FAIL loadmid_drop: got %b expected 0", load_pending);
      end
    end
    vectors++;
    if (ticks.size() != 3 || ticks[0] != 7 || ticks[1] != 12 || ticks[2] != 17) begin
      miscompares++; $display("[TB] FAIL loadmid_ticks: got %p expected '{7,12,17}", ticks);
    end
    vectors++;
    if (highs != 3) begin
      miscompares++; $display("[TB] FAIL loadmid_duty: got %0d high expected 3", highs);
    end
  endtask

  task automatic test_last_wins_and_wrap_load();
    int ticks[$];
    int highs = 0;
    bit l;
    int v;
    drive(1, 0, 0, 0); void'(sb.pop_front());
    for (int i = 1; i <= 28; i++) begin
      l = (i == 2) || (i == 3) || (i == 15);
      v = (i == 2) ? 7 : (i == 3) ? 4 : 6;
      drive(0, 1, l, v);
      exp_v = sb.pop_front(); vectors++;
      if ({clk_out, tick, load_pending} !== exp_v) begin
        miscompares++; $display("[TB] FAIL lastwins_sb cyc %0d: got %b expected %b", i, {clk_out, tick, load_pending}, exp_v);
      end
      if (tick) ticks.push_back(i);
      if (i >= 15 && i <= 20 && clk_out) highs++;
      if (i == 15 && load_pending !== 1'b0) begin
        miscompares++; $display("[TB] FAIL wrapload_pending: got %b expected 0", load_pending);
      end
    end
    vectors++;
    if (ticks.size() != 5 || ticks[0] != 1 || ticks[1] != 11 || ticks[2] != 15 || ticks[3] != 21 || ticks[4] != 27) begin
      miscompares++; $display("[TB] FAIL lastwins_ticks: got %p expected '{1,11,15,21,27}", ticks);
    end
    vectors++;
    if (highs != 3) begin
      miscompares++; $display("[TB] FAIL wrapload_duty: got %0d high expected 3", highs);
    end
  endtask

  task automatic test_clamp_and_max();
    bit prev = 0;
    bit l;
    int v;
    int highs = 1;
    int lows = 0;
    int first_tick = 0;
    drive(1, 0, 0, 0); void'(sb.pop_front());
    for (int i = 1; i <= 21; i++) begin
      l = (i == 2) || (i == 15) || (i == 21);
      v = (i == 2) ? 0 : (i == 15) ? 1 : 65535;
      drive(0, 1, l, v);
      exp_v = sb.pop_front(); vectors++;
      if ({clk_out, tick, load_pending} !== exp_v) begin
        miscompares++; $display("[TB] FAIL clamp_sb cyc %0d: got %b expected %b", i, {clk_out, tick, load_pending}, exp_v);
      end
      if (i >= 12 && (clk_out === prev || tick !== bit'(i % 2))) begin
        miscompares++; $display("[TB] FAIL clamp_toggle cyc %0d: got out=%b tick=%b expected out=%b tick=%b", i, clk_out, tick, ~prev, bit'(i % 2));
      end
      prev = clk_out;
    end
    for (int j = 1; j <= 65540 && first_tick == 0; j++) begin
      drive(0, 1, 0, 0);
      exp_v = sb.pop_front(); vectors++;
      if ({clk_out, tick, load_pending} !== exp_v) begin
        miscompares++; $display("[TB] FAIL max_sb cyc %0d: got %b expected %b", j, {clk_out, tick, load_pending}, exp_v);
      end
      if (tick) first_tick = j;
      else if (clk_out) highs++;
      else lows++;
    end
    vectors++;
    if (first_tick != 65535) begin
      miscompares++; $display("[TB] FAIL max_period: got tick at %0d expected 65535", first_tick);
    end
    vectors++;
    if (highs != 32768 || lows != 32767) begin
      miscompares++; $display("[TB] FAIL max_duty: got %0d/%0d expected 32768/32767", highs, lows);
    end
  endtask

  task automatic test_enable_freeze();
    int ticks[$];
    int highs = 0;
    bit e;
    drive(1, 0, 0, 0); void'(sb.pop_front());
    for (int i = 1; i <= 20; i++) begin
      e = !(i >= 4 && i <= 10);
      drive(0, e, 0, 0);
      exp_v = sb.pop_front(); vectors++;
      if ({clk_out, tick, load_pending} !== exp_v) begin
        miscompares++; $display("[TB] FAIL freeze_sb cyc %0d: got %b expected %b", i, {clk_out, tick, load_pending}, exp_v);
      end
      if (!e && {clk_out, tick} !== 2'b10) begin
        miscompares++; $display("[TB] FAIL freeze_hold cyc %0d: got %b expected 10", i, {clk_out, tick});
      end
      if (tick) ticks.push_back(i);
      if (i <= 17 && clk_out) highs++;
    end
    vectors++;
    if (ticks.size() != 2 || ticks[0] != 1 || ticks[1] != 18) begin
      miscompares++; $display("[TB] FAIL freeze_ticks: got %p expected '{1,18}", ticks);
    end
    vectors++;
    if (highs != 12) begin
      miscompares++; $display("[TB] FAIL freeze_duty: got %0d high expected 12", highs);
    end
  endtask

  task automatic test_reset_mid();
    int ticks[$];
    drive(1, 0, 0, 0); void'(sb.pop_front());
    for (int i = 1; i <= 20; i++) begin
      drive(i == 6, 1, i == 5, 3);
      exp_v = sb.pop_front(); vectors++;
      if ({clk_out, tick, load_pending} !== exp_v) begin
        miscompares++; $display("[TB] FAIL rstmid_sb cyc %0d: got %b expected %b", i, {clk_out, tick, load_pending}, exp_v);
      end
      if (i == 6 && {clk_out, tick, load_pending} !== 3'b000) begin
        miscompares++; $display("[TB] FAIL rstmid_state: got %b expected 000", {clk_out, tick, load_pending});
      end
      if (tick && i > 6) ticks.push_back(i);
    end
    vectors++;
    if (ticks.size() != 2 || ticks[0] != 7 || ticks[1] != 17) begin
      miscompares++; $display("[TB] FAIL rstmid_ticks: got %p expected '{7,17}", ticks);
    end
  endtask

  initial begin
    test_reset();
    test_default_period();
    test_load_mid();
    test_last_wins_and_wrap_load();
    test_clamp_and_max();
    test_enable_freeze();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frequency_divider_prog.md
Name: frequency_divider_prog

Overview:
Runtime-programmable integer clock divider. It is the parametrised successor to the fixed frequency_divider.
- Derives a divided clock-enable-grade square wave (clk_out) and a one-cycle period marker (tick) from clk_in.
- Divide ratio is loaded at runtime and takes effect glitch-free at the next period boundary.
- Sits between the board clock and slow peripheral/timer logic that needs several selectable rates.

Parameters:
DIV_WIDTH, 16, width of the divide ratio and internal phase counter.
DEFAULT_DIV, 10, ratio active out of reset; must satisfy 2 <= DEFAULT_DIV <= 2^DIV_WIDTH-1.

Ports:
clk_in  input  1  sole clock; all logic on its rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  count enable; low freezes the divider.
div_value  input  DIV_WIDTH  requested divide ratio N.
div_load  input  1  one-cycle strobe; captures div_value.
clk_out  output  1  divided output, registered.
tick  output  1  one-cycle pulse coincident with each clk_out rising edge, registered.
load_pending  output  1  high while a captured ratio waits for the next period boundary.

Behaviour:
- Single clock domain clk_in. Synchronous active-high reset rst. No negedge logic; no combinational path to any output.
- State:
  - active_div: ratio N in use.
  - pend_div and pend_flag: the captured ratio and its valid flag.
  - cnt: phase, DIV_WIDTH bits, range 0..N-1.
  - H = (N+1)>>1, the number of high cycles.
- Clamp: any captured div_value of 0 or 1 is stored as 2. Values 2..2^DIV_WIDTH-1 are used as-is.
- Reset (rst=1 at a clk_in edge):
  - active_div=DEFAULT_DIV, cnt=DEFAULT_DIV-1 (terminal), pend_flag=0.
  - clk_out=0, tick=0, load_pending=0.
  - rst overrides en and div_load in the same cycle.
- Wrap: wrap = en && (cnt == active_div-1).
- Per edge with en=1:
  - cnt <= wrap ? 0 : cnt+1.
  - clk_out <= (next cnt < H_next), where H_next is computed from the ratio in force after this edge.
  - tick <= wrap.
- Consequence: after reset with en=1, the first edge wraps. clk_out rises and tick pulses one cycle after the first enabled edge.
- Steady state: period N cycles, high H, low N-H.
  - Even N gives exactly 50% duty.
  - Odd N is high one cycle longer than low.
- Ratio update:
  - div_load=1 without wrap: pend_div <= clamp(div_value), pend_flag <= 1.
  - Several loads before a boundary: the last one wins.
  - On wrap with pend_flag=1: active_div <= pend_div, pend_flag <= 0. The new N governs the period starting at cnt=0.
  - div_load=1 on the same edge as wrap: clamp(div_value) becomes active_div immediately. Any older pending value is discarded and pend_flag <= 0.
- load_pending is a registered copy of pend_flag.
- No truncated or runt pulses: a ratio change never alters the period in progress.
- en=0:
  - cnt and clk_out hold their values; tick=0.
  - div_load is still captured into pending, but cannot apply until a wrap occurs with en=1.
  - Resuming continues from the frozen phase.
- Reset mid-period: the next edge forces the reset state. The pending load is lost and active_div reverts to DEFAULT_DIV.
- Max ratio 2^DIV_WIDTH-1: cnt never exceeds active_div-1, so there is no overflow.

Test Plan:
1. Reset, DEFAULT_DIV=10, en=1 held, 20 ns clk_in -> clk_out period 200 ns, 5 cycles high / 5 low. tick high 1 cycle every 10, aligned with clk_out rise. First rise 1 cycle after the first enabled edge.
2. Load div_value=5 mid-period -> load_pending=1; the current 10-cycle period completes unchanged. Next periods are 5 cycles, 3 high / 2 low. load_pending drops at the wrap.
3. Loads of 7 then 4 inside one period -> only 4 applies at the boundary. Load of 6 issued on the exact wrap edge -> 6-cycle period starts immediately, with no pending flag.
4. div_value=0 and div_value=1 -> both behave as N=2: clk_out toggles every cycle, tick every 2 cycles. div_value=65535 -> high 32768, low 32767.
5. en=0 for 7 cycles mid-high-phase -> clk_out frozen high, tick stays 0. After resume, remaining high cycles and total period are preserved: the period is stretched by exactly 7 cycles.
6. rst asserted mid-period with a pending load of 3 -> the next edge gives clk_out=0, tick=0, load_pending=0. The divider restarts at N=10; ratio 3 is never applied.
